// File: rtl/motor_pwm_driver_pkg.sv
// Shared types for the H-bridge PWM driver: direction codes,
// channel FSM states and small state predicates.
package motor_pwm_driver_pkg;

  typedef enum logic [1:0] {
    DIR_COAST = 2'b00,
    DIR_REV   = 2'b01,
    DIR_FWD   = 2'b10,
    DIR_BRAKE = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_DEAD,
    ST_BRAKE
  } state_e;

  localparam logic [1:0] PINS_OFF   = 2'b00;
  localparam logic [1:0] PINS_BRAKE = 2'b11;

  function automatic logic is_drive(state_e s);
    return (s == ST_RAMP) || (s == ST_RUN);
  endfunction

  function automatic logic is_busy(state_e s);
    return (s == ST_RAMP) || (s == ST_DEAD);
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: direction FSM, soft-start duty,
// reversal dead-time counter, registered pins and enable.
module motor_pwm_channel
  import motor_pwm_driver_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int DUTY_MAX  = 200,
  parameter int RAMP_STEP = 8,
  parameter int DEAD_CYC  = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          dir,
  input  logic                tick,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [1:0]          pins,
  output logic                en,
  output logic                busy_nxt
);

  localparam int DW = ($clog2(DEAD_CYC) > 0) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS:0]   STEP = (PWM_BITS+1)'(RAMP_STEP);

  state_e              state_q, state_d;
  dir_e                tgt_q, tgt_d;
  dir_e                cmd;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DW-1:0]       dead_q, dead_d;
  logic [1:0]          pins_q, pins_d;
  logic                en_q, en_d;
  logic [PWM_BITS:0]   ramp_sum;

  always_comb begin
    cmd      = dir_e'(dir);
    state_d  = state_q;
    tgt_d    = tgt_q;
    duty_d   = duty_q;
    dead_d   = dead_q;
    pins_d   = pins_q;
    ramp_sum = {1'b0, duty_q} + STEP;
    unique case (state_q)
      ST_RAMP, ST_RUN: begin
        unique case (cmd)
          DIR_COAST: begin
            state_d = ST_IDLE;
            pins_d  = PINS_OFF;
            duty_d  = '0;
          end
          DIR_BRAKE: begin
            state_d = ST_BRAKE;
            pins_d  = PINS_BRAKE;
            duty_d  = '0;
          end
          default: begin
            if (cmd != tgt_q) begin
              state_d = ST_DEAD;
              tgt_d   = cmd;
              pins_d  = PINS_OFF;
              duty_d  = '0;
              dead_d  = DW'(DEAD_CYC - 1);
            end else if (state_q == ST_RAMP && wrap && tick) begin
              if (ramp_sum >= {1'b0, DMAX}) begin
                duty_d  = DMAX;
                state_d = ST_RUN;
              end else begin
                duty_d = ramp_sum[PWM_BITS-1:0];
              end
            end
          end
        endcase
      end
      ST_DEAD: begin
        unique case (cmd)
          DIR_COAST: begin
            state_d = ST_IDLE;
            pins_d  = PINS_OFF;
          end
          DIR_BRAKE: begin
            state_d = ST_BRAKE;
            pins_d  = PINS_BRAKE;
          end
          default: begin
            // Latest direction wins; the dead interval is never extended.
            tgt_d = cmd;
            if (dead_q == '0) begin
              state_d = ST_RAMP;
              pins_d  = dir;
            end else begin
              dead_d = dead_q - DW'(1);
            end
          end
        endcase
      end
      default: begin
        duty_d = '0;
        unique case (cmd)
          DIR_FWD, DIR_REV: begin
            state_d = ST_RAMP;
            tgt_d   = cmd;
            pins_d  = dir;
          end
          DIR_BRAKE: begin
            state_d = ST_BRAKE;
            pins_d  = PINS_BRAKE;
          end
          default: begin
            state_d = ST_IDLE;
            pins_d  = PINS_OFF;
          end
        endcase
      end
    endcase
    en_d     = is_drive(state_d) ? (pwm_cnt < duty_d)
                                 : (state_d == ST_BRAKE);
    busy_nxt = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= DIR_COAST;
      duty_q  <= '0;
      dead_q  <= '0;
      pins_q  <= PINS_OFF;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      pins_q  <= pins_d;
      en_q    <= en_d;
    end
  end

  assign pins = pins_q;
  assign en   = en_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge driver: command register, shared PWM
// timebase and busy flag around two motor_pwm_channel instances.
module motor_pwm_driver
  import motor_pwm_driver_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int PRESC     = 195,
  parameter int DUTY_MAX  = 200,
  parameter int RAMP_STEP = 8,
  parameter int DEAD_CYC  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] motor_cmd,
  output logic [3:0] drv_in,
  output logic       ena,
  output logic       enb,
  output logic       busy
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [3:0]          cmd_q;
  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                busy_q, busy_d;
  logic                tick, wrap;
  logic [1:0]          pins_a, pins_b;
  logic                busy_a, busy_b;

  always_comb begin
    tick    = (presc_q == PW'(PRESC - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    pwm_d   = tick ? pwm_q + PWM_BITS'(1) : pwm_q;
    wrap    = tick && (pwm_q == '1);
    busy_d  = busy_a | busy_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      presc_q <= '0;
      pwm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      cmd_q   <= motor_cmd;
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
    end
  end

  // Channel A decodes {IN1,IN2}, so its pair is swapped in and out.
  motor_pwm_channel #(
    .PWM_BITS (PWM_BITS),
    .DUTY_MAX (DUTY_MAX),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_ch_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .dir     ({cmd_q[0], cmd_q[1]}),
    .tick    (tick),
    .wrap    (wrap),
    .pwm_cnt (pwm_q),
    .pins    (pins_a),
    .en      (ena),
    .busy_nxt(busy_a)
  );

  motor_pwm_channel #(
    .PWM_BITS (PWM_BITS),
    .DUTY_MAX (DUTY_MAX),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_ch_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .dir     (cmd_q[3:2]),
    .tick    (tick),
    .wrap    (wrap),
    .pwm_cnt (pwm_q),
    .pins    (pins_b),
    .en      (enb),
    .busy_nxt(busy_b)
  );

  assign drv_in = {pins_b, pins_a[0], pins_a[1]};
  assign busy   = busy_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed scenarios plus random
// commands, checked against a behavioural channel model.
module tb_motor_pwm_driver;

  localparam int PB = 4;
  localparam int PR = 1;
  localparam int DM = 12;
  localparam int RS = 4;
  localparam int DC = 3;
  localparam int PER = 1 << PB;

  localparam int M_IDLE = 0, M_RAMP = 1, M_RUN = 2, M_DEAD = 3, M_BRAKE = 4;
  localparam int D_COAST = 0, D_FWD = 1, D_REV = 2, D_BRAKE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] motor_cmd = 4'b0000;
  logic [3:0] drv_in;
  logic       ena, enb, busy;

  motor_pwm_driver #(
    .PWM_BITS (PB),
    .PRESC    (PR),
    .DUTY_MAX (DM),
    .RAMP_STEP(RS),
    .DEAD_CYC (DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .motor_cmd(motor_cmd),
    .drv_in   (drv_in),
    .ena      (ena),
    .enb      (enb),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_cmd, pk;
  int md[2], du[2], dc[2], tg[2];
  int e_drv, e_busy;
  int e_en[2];

  logic [3:0] r_drv [1024];
  bit         r_ena [1024];
  bit         r_enb [1024];
  bit         r_busy[1024];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s at edge %0d: got=%0d exp=%0d", tag, pk, got, exp);
    end
  endtask

  function automatic int dec(input int hi, input int lo);
    if (hi == 1 && lo == 0) return D_FWD;
    if (hi == 0 && lo == 1) return D_REV;
    if (hi == 1) return D_BRAKE;
    return D_COAST;
  endfunction

  // Pin pair {hi,lo} that a channel presents in its current mode.
  function automatic int pins(input int c);
    if (md[c] == M_BRAKE) return 3;
    if (md[c] == M_RAMP || md[c] == M_RUN) return (tg[c] == D_FWD) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_cmd = 0;
    pk = 0;
    for (int c = 0; c < 2; c++) begin
      md[c] = M_IDLE; du[c] = 0; dc[c] = 0; tg[c] = D_COAST; e_en[c] = 0;
    end
    e_drv = 0;
    e_busy = 0;
  endtask

  task automatic model_ch(input int c, input int d, input bit wr, input int pwmb);
    if (md[c] == M_RAMP || md[c] == M_RUN) begin
      if (d == D_COAST) begin md[c] = M_IDLE; du[c] = 0; end
      else if (d == D_BRAKE) begin md[c] = M_BRAKE; du[c] = 0; end
      else if (d != tg[c]) begin
        md[c] = M_DEAD; dc[c] = DC - 1; tg[c] = d; du[c] = 0;
      end else if (md[c] == M_RAMP && wr) begin
        du[c] = (du[c] + RS > DM) ? DM : du[c] + RS;
        if (du[c] == DM) md[c] = M_RUN;
      end
    end else if (md[c] == M_DEAD) begin
      if (d == D_COAST) md[c] = M_IDLE;
      else if (d == D_BRAKE) md[c] = M_BRAKE;
      else begin
        tg[c] = d;
        if (dc[c] == 0) md[c] = M_RAMP;
        else dc[c] = dc[c] - 1;
      end
    end else begin
      du[c] = 0;
      if (d == D_FWD || d == D_REV) begin md[c] = M_RAMP; tg[c] = d; end
      else if (d == D_BRAKE) md[c] = M_BRAKE;
      else md[c] = M_IDLE;
    end
    if (md[c] == M_RAMP || md[c] == M_RUN) e_en[c] = (pwmb < du[c]) ? 1 : 0;
    else e_en[c] = (md[c] == M_BRAKE) ? 1 : 0;
  endtask

  task automatic model_edge();
    int pwmb, pa, pb;
    pwmb = pk % PER;
    model_ch(0, dec(m_cmd & 1, (m_cmd >> 1) & 1), pwmb == PER - 1, pwmb);
    model_ch(1, dec((m_cmd >> 3) & 1, (m_cmd >> 2) & 1), pwmb == PER - 1, pwmb);
    m_cmd = int'(motor_cmd);
    pk++;
    pa = pins(0);
    pb = pins(1);
    e_drv = (pb << 2) | ((pa & 1) << 1) | (pa >> 1);
    e_busy = 0;
    for (int c = 0; c < 2; c++)
      if (md[c] == M_RAMP || md[c] == M_DEAD) e_busy = 1;
  endtask

  task automatic sample();
    if (pk < 1024) begin
      r_drv[pk] = drv_in; r_ena[pk] = ena;
      r_enb[pk] = enb; r_busy[pk] = busy;
    end
    chk("drv_in", drv_in, e_drv);
    chk("ena", ena, e_en[0]);
    chk("enb", enb, e_en[1]);
    chk("busy", busy, e_busy);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    sample();
  endtask

  task automatic run_to(input int k);
    while (pk < k) step();
  endtask

  task automatic do_reset();
    motor_cmd = 4'b0000;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_drv", drv_in, 0);
    chk("rst_async_ena", ena, 0);
    chk("rst_async_enb", enb, 0);
    chk("rst_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sample();
  endtask

  function automatic int win(input bit b, input int w);
    int s = 0;
    for (int k = PER * w; k < PER * w + PER; k++)
      s += b ? int'(r_enb[k]) : int'(r_ena[k]);
    return s;
  endfunction

  function automatic int cnt_a_off(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) if (r_drv[k][1:0] == 2'b00) s++;
    return s;
  endfunction

  function automatic int cnt_ena(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) s += int'(r_ena[k]);
    return s;
  endfunction

  int ramp_exp[5] = '{0, 4, 8, 12, 12};
  int rev_exp[4]  = '{1, 4, 8, 12};

  initial begin
    do_reset();

    motor_cmd = 4'b1001;
    run_to(80);
    chk("start_drv_k1", r_drv[1], 0);
    chk("start_drv_k2", r_drv[2], 4'b1001);
    for (int w = 0; w < 5; w++) begin
      chk("ramp_win_a", win(1'b0, w), ramp_exp[w]);
      chk("ramp_win_b", win(1'b1, w), ramp_exp[w]);
    end
    chk("ramp_busy_k47", r_busy[47], 1);
    chk("ramp_busy_k48", r_busy[48], 0);

    motor_cmd = 4'b1010;
    run_to(143);
    chk("rev_dead_len", cnt_a_off(81, 95), 3);
    chk("rev_dead_ena", cnt_ena(82, 84), 0);
    chk("rev_b_pins", r_drv[83][3:2], 2'b10);
    chk("rev_drv_k85", r_drv[85], 4'b1010);
    for (int w = 0; w < 4; w++) begin
      chk("rev_win_a", win(1'b0, w + 5), rev_exp[w]);
      chk("rev_win_b", win(1'b1, w + 5), 12);
    end
    chk("rev_busy_k128", r_busy[128], 0);

    motor_cmd = 4'b1001;
    step();
    motor_cmd = 4'b1010;
    step();
    motor_cmd = 4'b1001;
    run_to(165);
    chk("dd_dead_len", cnt_a_off(144, 160), 3);
    chk("dd_drv_k147", r_drv[147][1:0], 0);
    chk("dd_drv_k148", r_drv[148], 4'b1001);
    chk("dd_win_b", win(1'b1, 9), 12);

    motor_cmd = 4'b0000;
    run_to(175);
    chk("coast_drv_k166", r_drv[166], 4'b1001);
    chk("coast_drv_k167", r_drv[167], 0);
    chk("coast_en_k167", int'(r_ena[167]) + int'(r_enb[167]), 0);
    chk("coast_busy_k166", r_busy[166], 1);
    chk("coast_busy_k167", r_busy[167], 0);

    motor_cmd = 4'b1001;
    run_to(230);
    motor_cmd = 4'b0011;
    run_to(250);
    chk("brake_drv_k232", r_drv[232], 4'b0011);
    chk("brake_ena_on", cnt_ena(232, 250), 19);
    chk("brake_enb_k232", r_enb[232], 0);

    motor_cmd = 4'b0001;
    run_to(288);
    chk("unbrake_drv_k251", r_drv[251], 4'b0011);
    chk("unbrake_drv_k252", r_drv[252], 4'b0001);
    chk("unbrake_busy_k251", r_busy[251], 0);
    chk("unbrake_busy_k252", r_busy[252], 1);
    chk("unbrake_win_a", win(1'b0, 16), 4);

    motor_cmd = 4'b1001;
    run_to(300);
    chk("prerst_busy", r_busy[300], 1);
    do_reset();
    run_to(20);
    chk("postrst_drv", r_drv[20], 0);
    chk("postrst_ena", cnt_ena(1, 20), 0);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      int n;
      if ($urandom_range(0, 19) == 0) do_reset();
      motor_cmd = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 40);
      repeat (n) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
